// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4 memory bridge.
//   - state_e    : bridge FSM states (also exported on the debug port)
//   - BURST_INCR : AXI INCR burst encoding
//   - RESP_OKAY  : AXI OKAY response encoding
//   - *_W        : AXI channel field widths
//   - clamp_len  : limits a requested read length to the configured maximum
package axi_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int STRB_W  = 8;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [RESP_W-1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_RDATA = 3'd2,
    S_AW_W  = 3'd3,
    S_B     = 3'd4
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/axi_mem_bridge.sv
// axi_mem_bridge: converts the core's simple memory request port into AXI4
// master transactions. Reads are INCR bursts (length clamped to MAX_LEN),
// writes are single beat. Exactly one transaction is in flight at a time.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   req_*                  request port (valid/ready, wen, addr, len, size, wdata, wstrb)
//   rsp_*                  response port (valid/ready, data, last)
//   err                    sticky response-error flag
//   ar*/r*                 AXI read address / read data channels
//   aw*/w*/b*              AXI write address / write data / write response channels
//   dbg_state              current FSM state, for observation only
//
// Handshake rule used on every channel: a transfer happens on a rising aclk
// edge where valid && ready. A valid, once raised, holds its payload stable
// until that edge. No valid output depends combinationally on any ready input;
// rready follows rsp_ready combinationally (ready-to-ready path only).
//
// Optional feature: define AXI_BRIDGE_RESP_CHECK_EN to enable the sticky err
// flag (rresp/bresp != OKAY, missing rlast on the final beat, early rlast).
// Without it err is tied low and the FSM behaves identically.
module axi_mem_bridge
  import axi_pkg::*;
#(
  parameter logic [ID_W-1:0]  AXI_ID  = 4'd0,
  parameter logic [LEN_W-1:0] MAX_LEN = 8'd7
) (
  input  logic                aclk,
  input  logic                aresetn,
  // request / response port
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [SIZE_W-1:0]   req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [STRB_W-1:0]   req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_last,
  output logic                err,
  // AXI read address
  output logic [ADDR_W-1:0]   araddr,
  output logic [ID_W-1:0]     arid,
  output logic [LEN_W-1:0]    arlen,
  output logic [SIZE_W-1:0]   arsize,
  output logic [BURST_W-1:0]  arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [RESP_W-1:0]   rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [ADDR_W-1:0]   awaddr,
  output logic [ID_W-1:0]     awid,
  output logic [LEN_W-1:0]    awlen,
  output logic [SIZE_W-1:0]   awsize,
  output logic [BURST_W-1:0]  awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [ID_W-1:0]     bid,
  input  logic [RESP_W-1:0]   bresp,
  input  logic                bvalid,
  output logic                bready,
  // observation
  output state_e              dbg_state
);

  state_e              state_q, state_d;
  logic                rst_done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [SIZE_W-1:0]   size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [LEN_W-1:0]    beat_cnt_q;
  logic                aw_done_q, w_done_q;
  logic                b_pulse_q;

  logic req_fire, ar_fire, r_fire, aw_fire, w_fire, b_fire, r_end;

  assign req_fire = req_valid && req_ready;
  assign ar_fire  = arvalid && arready;
  assign r_fire   = rvalid && rready;
  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign b_fire   = bvalid && bready;
  // A burst ends on rlast, or on the beat that reaches the requested length
  // even if the slave forgot rlast, so a misbehaving slave cannot hang us.
  assign r_end    = r_fire && (rlast || (beat_cnt_q == len_q));

  // ---------------- state register ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_fire) state_d = req_wen ? S_AW_W : S_AR;
      S_AR:    if (ar_fire)  state_d = S_RDATA;
      S_RDATA: if (r_end)    state_d = S_IDLE;
      S_AW_W:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = S_B;
      S_B:     if (b_fire)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rsp_valid = b_pulse_q;
    rsp_last  = b_pulse_q;
    unique case (state_q)
      S_IDLE:  req_ready = rst_done_q;
      S_AR:    arvalid   = 1'b1;
      S_RDATA: begin
        rready    = rsp_ready;
        rsp_valid = rvalid;
        rsp_last  = rlast;
      end
      S_AW_W: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      S_B:     bready    = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;
  assign rsp_data  = rdata;

  // ---------------- request / progress registers ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rst_done_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      beat_cnt_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_pulse_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      // Write-done is reported one cycle after the B handshake.
      b_pulse_q  <= b_fire;
      if (req_fire) begin
        addr_q     <= req_addr;
        len_q      <= clamp_len(req_len, MAX_LEN);
        size_q     <= (req_size > 3'd3) ? 3'd3 : req_size;
        wdata_q    <= req_wdata;
        wstrb_q    <= req_wstrb;
        beat_cnt_q <= '0;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      // Saturates at len so a long burst from the slave cannot wrap the count.
      if (r_fire && (beat_cnt_q != len_q)) beat_cnt_q <= beat_cnt_q + 8'd1;
    end
  end

  // ---------------- fixed / registered AXI fields ----------------
  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awaddr  = addr_q;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // ---------------- response error flag ----------------
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  logic err_q;
  logic err_set;
  logic unused_ids;

  assign err_set = (r_fire && ((rresp != RESP_OKAY) ||
                               ((beat_cnt_q == len_q) && !rlast) ||
                               (rlast && (beat_cnt_q != len_q)))) ||
                   (b_fire && (bresp != RESP_OKAY));

  always_ff @(posedge aclk) begin
    if (!aresetn)     err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err        = err_q;
  assign unused_ids = ^{rid, bid};
`else
  logic unused_resp;

  assign err         = 1'b0;
  assign unused_resp = ^{rid, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Bench for axi_mem_bridge: directed vector table, multi-cycle corner
// sequences (backpressure, mid-burst reset, error response) and randomized
// traffic, checked against a word-addressed reference memory and an expected
// response queue.
module tb_axi_mem_bridge;
  import axi_pkg::*;

  localparam logic [7:0] MAX_LEN = 8'd7;
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // ---------------- DUT signals ----------------
  logic        aclk, aresetn;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_last, err;
  logic [63:0] rsp_data;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;
  state_e      dbg_state;

  axi_mem_bridge #(.AXI_ID(4'd0), .MAX_LEN(MAX_LEN)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .err(err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  int rsp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // ---------------- memories ----------------
  logic [63:0] slave_mem [logic [28:0]];
  logic [63:0] ref_mem   [logic [28:0]];

  function automatic logic [63:0] init_word(input logic [28:0] idx);
    return {3'b101, idx, ~idx, 3'b011};
  endfunction

  function automatic logic [63:0] slave_rd(input logic [28:0] idx);
    return slave_mem.exists(idx) ? slave_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [28:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- AXI slave (sim_sram stand-in) ----------------
  logic        s_rd_active;
  logic [31:0] s_rd_addr, s_aw_addr, s_ra;
  logic [7:0]  s_rd_len, s_rd_beat, s_nb;
  logic [2:0]  s_rd_size;
  logic        s_aw_got, s_w_got;
  logic [63:0] s_w_data;
  logic [7:0]  s_w_strb;
  logic [7:0]  last_axlen;
  logic        last_wlast;
  logic [1:0]  inject_bresp;

  assign rid   = 4'd0;
  assign bid   = 4'd0;
  assign rresp = 2'b00;

  always @(posedge aclk) begin
    if (!aresetn) begin
      arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rdata <= '0;
      s_rd_active <= 1'b0; s_rd_beat <= '0;
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      s_aw_got <= 1'b0; s_w_got <= 1'b0;
    end else begin
      arready <= ($urandom_range(0, 2) == 0);
      awready <= ($urandom_range(0, 1) == 0);
      wready  <= ($urandom_range(0, 1) == 0);
      if (arvalid && arready && !s_rd_active) begin
        s_rd_active <= 1'b1; s_rd_addr <= araddr; s_rd_len <= arlen;
        s_rd_size <= arsize; s_rd_beat <= '0; last_axlen <= arlen;
      end
      if (s_rd_active && (!rvalid || rready)) begin
        if (rvalid && rlast) begin
          s_rd_active <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
        end else begin
          s_nb = rvalid ? s_rd_beat + 8'd1 : s_rd_beat;
          s_rd_beat <= s_nb;
          if ($urandom_range(0, 3) != 0) begin
            s_ra = s_rd_addr + (32'(s_nb) << s_rd_size);
            rvalid <= 1'b1; rdata <= slave_rd(s_ra[31:3]); rlast <= (s_nb == s_rd_len);
          end else begin
            rvalid <= 1'b0;
          end
        end
      end
      if (awvalid && awready) begin
        s_aw_addr <= awaddr; s_aw_got <= 1'b1; last_axlen <= awlen;
      end
      if (wvalid && wready) begin
        s_w_data <= wdata; s_w_strb <= wstrb; s_w_got <= 1'b1; last_wlast <= wlast;
      end
      if (s_aw_got && s_w_got) begin
        slave_mem[s_aw_addr[31:3]] = merge(slave_rd(s_aw_addr[31:3]), s_w_data, s_w_strb);
        s_aw_got <= 1'b0; s_w_got <= 1'b0; bvalid <= 1'b1; bresp <= inject_bresp;
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  // ---------------- response backpressure driver ----------------
  int   hold_cnt   = 0;
  logic rand_ready = 1'b0;

  always @(posedge aclk) begin
    #1;
    if (hold_cnt > 0) begin
      rsp_ready = 1'b0;
      hold_cnt--;
    end else begin
      rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- scoreboard: {is_write, last, data} ----------------
  logic [65:0] exp_q[$];
  logic [65:0] exp_e;

  always @(negedge aclk) begin
    if (aresetn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h, required no response", rsp_data);
      end else begin
        exp_e = exp_q[0];
        if (exp_e[65]) begin
          void'(exp_q.pop_front());
          check("wr_done_last", 64'(rsp_last), 64'd1);
          rsp_cnt++;
        end else if (rsp_ready) begin
          void'(exp_q.pop_front());
          check("rd_data", rsp_data, exp_e[63:0]);
          check("rd_last", 64'(rsp_last), 64'(exp_e[64]));
          rsp_cnt++;
        end
      end
    end
  end

  // AR payload must stay put while waiting for arready.
  logic        ar_wait_prev = 1'b0;
  logic [43:0] ar_prev;

  always @(negedge aclk) begin
    if (aresetn && ar_wait_prev)
      check("ar_hold", 64'({arvalid, araddr, arlen, arsize}), 64'(ar_prev));
    ar_wait_prev = aresetn && arvalid && !arready;
    ar_prev      = {arvalid, araddr, arlen, arsize};
  end

  // ---------------- reference model and driver tasks ----------------
  task automatic model_req(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [63:0] wd, input logic [7:0] ws);
    int          n;
    logic [31:0] a;
    if (wen) begin
      ref_mem[addr[31:3]] = merge(ref_rd(addr[31:3]), wd, ws);
      exp_q.push_back({1'b1, 1'b1, 64'd0});
    end else begin
      n = (len > MAX_LEN) ? int'(MAX_LEN) : int'(len);
      for (int i = 0; i <= n; i++) begin
        a = addr + 32'(i << size);
        exp_q.push_back({1'b0, (i == n), ref_rd(a[31:3])});
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_req(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [63:0] wd, input logic [7:0] ws);
    int waited = 0;
    req_wen = wen; req_addr = addr; req_len = len; req_size = size;
    req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    @(negedge aclk);
    while (!req_ready && waited < 200) begin
      @(negedge aclk);
      waited++;
    end
    if (!req_ready) begin
      n_total++;
      $display("FAIL req_accept: got req_ready=0 after 200 cycles, required 1");
    end
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge aclk);
      waited++;
    end
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [63:0] wd, input logic [7:0] ws);
    model_req(wen, addr, len, size, wd, ws);
    send_req(wen, addr, len, size, wd, ws);
    wait_drain();
  endtask

  task automatic wait_beats(input int target);
    int waited = 0;
    while (rsp_cnt < target && waited < 500) begin
      @(negedge aclk);
      waited++;
    end
    if (rsp_cnt < target) begin
      n_total++;
      $display("FAIL wait_beats: got %0d beats, required %0d", rsp_cnt, target);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          exp_beats;
    logic [7:0]  exp_axlen;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          start;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] word;

    vecs[0] = '{1'b0, 32'h8000_0000, 8'd0,   3'd3, 64'd0, 8'h00, 1, 8'd0};
    vecs[1] = '{1'b0, 32'h8000_0040, 8'd7,   3'd3, 64'd0, 8'h00, 8, 8'd7};
    vecs[2] = '{1'b1, 32'h8000_1000, 8'd0,   3'd3, 64'hDEADBEEF_CAFEF00D, 8'h0F, 1, 8'd0};
    vecs[3] = '{1'b0, 32'h8000_1000, 8'd0,   3'd3, 64'd0, 8'h00, 1, 8'd0};
    vecs[4] = '{1'b0, 32'h8000_0100, 8'd20,  3'd3, 64'd0, 8'h00, 8, 8'd7};
    vecs[5] = '{1'b0, 32'h8000_0004, 8'd3,   3'd2, 64'd0, 8'h00, 4, 8'd3};
    vecs[6] = '{1'b1, 32'h8000_0103, 8'd5,   3'd0, 64'h0000_0000_AB00_0000, 8'h08, 1, 8'd0};
    vecs[7] = '{1'b0, 32'h8000_0100, 8'd8,   3'd3, 64'd0, 8'h00, 8, 8'd7};
    vecs[8] = '{1'b0, 32'h8000_0000, 8'd255, 3'd0, 64'd0, 8'h00, 8, 8'd7};

    aresetn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_len = '0;
    req_size = '0; req_wdata = '0; req_wstrb = '0; inject_bresp = 2'b00;

    // ---- reset state ----
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_last}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_addr_regs", 64'({araddr, awaddr}), 64'd0);
    check("rst_wdata", wdata, 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("req_ready_release_cycle", 64'(req_ready), 64'd0);
    @(negedge aclk);
    check("req_ready_after_release", 64'(req_ready), 64'd1);
    check("fixed_burst", 64'({arburst, awburst}), 64'({BURST_INCR, BURST_INCR}));
    check("fixed_aw_w", 64'({awlen, wlast}), 64'({8'd0, 1'b1}));
    check("fixed_tieoffs", 64'({arlock, arcache, arprot, awlock, awcache, awprot}), 64'd0);
    @(posedge aclk);
    #1;

    // ---- directed vectors ----
    for (int i = 0; i < 9; i++) begin
      start = rsp_cnt;
      do_txn(vecs[i].wen, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].wdata, vecs[i].wstrb);
      check("vec_beats", 64'(rsp_cnt - start), 64'(vecs[i].exp_beats));
      check("vec_axlen", 64'(last_axlen), 64'(vecs[i].exp_axlen));
      check("vec_idle", 64'(dbg_state), 64'(S_IDLE));
      if (vecs[i].wen) begin
        check("vec_wlast", 64'(last_wlast), 64'd1);
        check("vec_mem_update", slave_rd(vecs[i].addr[31:3]), ref_rd(vecs[i].addr[31:3]));
      end
    end
    word = slave_rd(29'(32'h8000_1000 >> 3));
    check("mem_low_word", 64'(word[31:0]), 64'hCAFEF00D);

    // ---- backpressure mid-burst ----
    start = rsp_cnt;
    model_req(1'b0, 32'h8000_0080, 8'd7, 3'd3, 64'd0, 8'h00);
    send_req(1'b0, 32'h8000_0080, 8'd7, 3'd3, 64'd0, 8'h00);
    wait_beats(start + 3);
    hold_cnt = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("stall_rready", 64'(rready), 64'd0);
    end
    check("stall_state", 64'(dbg_state), 64'(S_RDATA));
    @(posedge aclk);
    #1;
    wait_drain();
    check("stall_beats", 64'(rsp_cnt - start), 64'd8);

    // ---- reset in the middle of a read burst ----
    start = rsp_cnt;
    model_req(1'b0, 32'h8000_00C0, 8'd7, 3'd3, 64'd0, 8'h00);
    send_req(1'b0, 32'h8000_00C0, 8'd7, 3'd3, 64'd0, 8'h00);
    wait_beats(start + 2);
    @(posedge aclk);
    #1;
    check("pre_abort_state", 64'(dbg_state), 64'(S_RDATA));
    aresetn = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    check("abort_valids", 64'({arvalid, awvalid, wvalid, rsp_valid, rready}), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    start = rsp_cnt;
    do_txn(1'b0, 32'h8000_0040, 8'd3, 3'd3, 64'd0, 8'h00);
    check("post_abort_beats", 64'(rsp_cnt - start), 64'd4);

    // ---- randomized traffic ----
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      size = 3'($urandom_range(0, 3));
      addr = 32'h8000_0000 + 32'($urandom_range(0, 63) << 3)
           + 32'(($urandom_range(0, 7) >> size) << size);
      do_txn(($urandom_range(0, 2) == 0), addr, 8'($urandom_range(0, 10)), size,
             {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end
    rand_ready = 1'b0;
    check("err_clean", 64'(err), 64'd0);

    // ---- error response on B ----
    inject_bresp = 2'b10;
    do_txn(1'b1, 32'h8000_0200, 8'd0, 3'd3, 64'h1122_3344_5566_7788, 8'hFF);
    inject_bresp = 2'b00;
    check("err_after_bresp", 64'(err), 64'(EXP_ERR));
    do_txn(1'b0, 32'h8000_0200, 8'd1, 3'd3, 64'd0, 8'h00);
    check("err_sticky", 64'(err), 64'(EXP_ERR));
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("err_cleared_by_reset", 64'(err), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    repeat (3) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
